// File: rtl/isolde_vlen_fetch_assembler_if.sv
// Handshake bundle between the fetch FIFO, the length assembler and the ISOLDE decoder.
// The slave modport is the assembler's view; the master modport is the surrounding fetch/decode side.
interface isolde_vlen_fetch_assembler_if #(
    parameter int unsigned MAX_WORDS = 5,
    parameter int unsigned ADDR_W    = 32
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [31:0]             in_rdata_i;
    logic [ADDR_W-1:0]       in_addr_i;
    logic                    in_err_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [32*MAX_WORDS-1:0] out_instr_o;
    logic [2:0]              out_len_o;
    logic [ADDR_W-1:0]       out_addr_o;
    logic                    out_illegal_o;
    logic                    out_err_o;

    modport slave (
        input  in_valid_i, in_rdata_i, in_addr_i, in_err_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_len_o, out_addr_o,
               out_illegal_o, out_err_o
    );

    modport master (
        output in_valid_i, in_rdata_i, in_addr_i, in_err_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_len_o, out_addr_o,
               out_illegal_o, out_err_o
    );
endinterface

// File: rtl/isolde_vlen_fetch_assembler.sv
// Collects 1, 2, 3 or 5 fetch words into one variable-length instruction bundle for the
// ISOLDE decoder; the length is decoded from the first word's opcode and nnn field.
module isolde_vlen_fetch_assembler #(
    parameter int unsigned MAX_WORDS = 5,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    isolde_vlen_fetch_assembler_if.slave bus
);
    localparam int unsigned BUNDLE_W = 32 * MAX_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              state_r;
    logic [2:0]          cnt_r;
    logic [2:0]          exp_len_r;
    logic [BUNDLE_W-1:0] instr_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [2:0]          len_r;
    logic                valid_r;
    logic                illegal_r;
    logic                err_r;

    logic [3:0]          dec_s;
    logic [2:0]          dec_len_s;
    logic                dec_ill_s;
    logic                accept_s;
    logic                release_s;

    // Returns {illegal, length} for a candidate first word.
    function automatic logic [3:0] decode_len(input logic [31:0] word);
        logic [3:0] res;
        case (word[6:0])
            7'b1111111: begin
                case (word[14:12])
                    3'd5:    res = {1'b0, 3'd5};
                    3'd1:    res = {1'b0, 3'd3};
                    default: res = {1'b1, 3'd1};
                endcase
            end
            7'b0111111: res = {1'b0, 3'd2};
            default:    res = {1'b0, 3'd1};
        endcase
        return res;
    endfunction

    assign dec_s     = decode_len(bus.in_rdata_i);
    assign dec_ill_s = dec_s[3];
    assign dec_len_s = dec_s[2:0];

    // Flush gates ready directly so the word presented in a flush cycle is never taken.
    assign bus.in_ready_o = ((state_r == ST_IDLE) || (state_r == ST_COLLECT)) && !flush_i;
    assign accept_s       = bus.in_valid_i && bus.in_ready_o;
    assign release_s      = (state_r == ST_HOLD) && bus.out_ready_i;

    // Assembly FSM: every output is a register, cleared on reset, flush or consumption.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || release_s) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            exp_len_r <= 3'd0;
            instr_r   <= {BUNDLE_W{1'b0}};
            addr_r    <= {ADDR_W{1'b0}};
            len_r     <= 3'd0;
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        instr_r   <= {{(BUNDLE_W-32){1'b0}}, bus.in_rdata_i};
                        addr_r    <= bus.in_addr_i;
                        exp_len_r <= dec_len_s;
                        illegal_r <= dec_ill_s;
                        err_r     <= bus.in_err_i;
                        if ((dec_len_s == 3'd1) || bus.in_err_i) begin
                            state_r <= ST_HOLD;
                            len_r   <= 3'd1;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_COLLECT;
                            cnt_r   <= 3'd1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (accept_s) begin
                        for (int k = 1; k < int'(MAX_WORDS); k++) begin
                            if (cnt_r == 3'(k)) begin
                                instr_r[32*k +: 32] <= bus.in_rdata_i;
                            end
                        end
                        cnt_r <= cnt_r + 3'd1;
                        err_r <= bus.in_err_i;
                        // An erroring word still counts toward the captured length.
                        if (((cnt_r + 3'd1) == exp_len_r) || bus.in_err_i) begin
                            state_r <= ST_HOLD;
                            len_r   <= cnt_r + 3'd1;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_COLLECT;
                        end
                    end else begin
                        state_r <= ST_COLLECT;
                    end
                end
                ST_HOLD: begin
                    state_r <= ST_HOLD;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid_o   = valid_r;
    assign bus.out_instr_o   = instr_r;
    assign bus.out_len_o     = len_r;
    assign bus.out_addr_o    = addr_r;
    assign bus.out_illegal_o = illegal_r;
    assign bus.out_err_o     = err_r;
endmodule

// File: tb/tb_isolde_vlen_fetch_assembler.sv
// Randomized scoreboard bench for the variable-length fetch assembler: the driver pushes the
// reference bundle when an instruction is issued and a monitor pops it when decode consumes one.
module tb_isolde_vlen_fetch_assembler;
    localparam int MW = 5;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    isolde_vlen_fetch_assembler_if #(.MAX_WORDS(MW), .ADDR_W(AW)) bus ();

    isolde_vlen_fetch_assembler #(.MAX_WORDS(MW), .ADDR_W(AW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [159:0] instr;
        logic [2:0]   len;
        logic [31:0]  addr;
        logic         ill;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   rdy_mode = 2;   // 0 random, 1 held low, 2 held high

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: length from the opcode rules, truncated at the first erroring word.
    function automatic exp_t model(input logic [31:0] w[MW], input int err_at, input logic [31:0] a);
        exp_t e;
        int full;
        int n;
        logic [6:0] op;
        logic [2:0] nnn;
        op = w[0][6:0];
        nnn = w[0][14:12];
        e.ill = 1'b0;
        if (op == 7'h7F) begin
            if (nnn == 3'd5) full = 5;
            else if (nnn == 3'd1) full = 3;
            else begin full = 1; e.ill = 1'b1; end
        end else if (op == 7'h3F) full = 2;
        else full = 1;
        e.err = (err_at >= 0) && (err_at < full);
        n = e.err ? err_at + 1 : full;
        e.instr = '0;
        for (int k = 0; k < n; k++) e.instr[32*k +: 32] = w[k];
        e.len = 3'(n);
        e.addr = a;
        return e;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic [31:0] a, input logic e, input bit is_last);
        bit acc = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_rdata_i = d;
        bus.in_addr_i  = a;
        bus.in_err_i   = e;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk);
            #1;
            if (acc && is_last) chk("latency_valid", 160'(bus.out_valid_o), 160'd1);
            #1;
        end
        if (!acc) chk("accept_timeout", 160'd0, 160'd1);
        bus.in_valid_i = 1'b0;
        bus.in_err_i   = 1'b0;
    endtask

    // Sends an instruction; stop_after >= 0 abandons it after that many words.
    task automatic send_instr(input logic [31:0] w[MW], input logic [31:0] a, input int err_at,
                              input bit push, input int stop_after, input bit gaps);
        exp_t e;
        int n;
        e = model(w, err_at, a);
        n = int'(e.len);
        if (push) exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            if (stop_after >= 0 && k == stop_after) return;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
            send_word(w[k], a + 32'(4 * k), (k == err_at), (k == n - 1));
        end
    endtask

    // Decoder-side ready generator.
    initial begin
        bus.out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready_i = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready_i = 1'b0;
                default: bus.out_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: checks hold stability and pops the scoreboard on each consumed bundle.
    bit           hold_pend = 1'b0;
    logic [159:0] held_instr;
    logic [38:0]  held_meta;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 160'(bus.out_valid_o), 160'd1);
                    chk("hold_instr", bus.out_instr_o, held_instr);
                    chk("hold_meta", 160'({bus.out_len_o, bus.out_addr_o, bus.out_illegal_o, bus.out_err_o}),
                        160'(held_meta));
                end
                if (bus.out_valid_o && !flush) chk("in_ready_in_hold", 160'(bus.in_ready_o), 160'd0);
                if (bus.out_valid_o && !flush && bus.out_ready_i) begin
                    hold_pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bundle", 160'd1, 160'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr", bus.out_instr_o, e.instr);
                        chk("len", 160'(bus.out_len_o), 160'(e.len));
                        chk("addr", 160'(bus.out_addr_o), 160'(e.addr));
                        chk("illegal", 160'(bus.out_illegal_o), 160'(e.ill));
                        chk("err", 160'(bus.out_err_o), 160'(e.err));
                    end
                end else if (bus.out_valid_o && !flush) begin
                    hold_pend  = 1'b1;
                    held_instr = bus.out_instr_o;
                    held_meta  = {bus.out_len_o, bus.out_addr_o, bus.out_illegal_o, bus.out_err_o};
                end else begin
                    hold_pend = 1'b0;
                end
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 160'(bus.out_valid_o), 160'd0);
        chk({name, "_instr"}, bus.out_instr_o, 160'd0);
        chk({name, "_meta"}, 160'({bus.out_len_o, bus.out_addr_o, bus.out_illegal_o, bus.out_err_o}), 160'd0);
    endtask

    initial begin
        logic [31:0] w[MW];
        exp_t probe;
        int err_at;
        int cls;
        logic [2:0] nnn;
        logic [2:0] bad_nnn[6];
        bad_nnn = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_rdata_i = 32'd0;
        bus.in_addr_i  = 32'd0;
        bus.in_err_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 160'(bus.in_ready_o), 160'd1);
        @(posedge clk);
        #2;

        // 5-word GE80 at 0x100 with valid held high.
        w = '{32'h0000_507F, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        send_instr(w, 32'h100, -1, 1'b1, -1, 1'b0);

        // 2-word with three cycles of backpressure.
        rdy_mode = 1;
        w = '{32'h0E00_003F, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0};
        send_instr(w, 32'h200, -1, 1'b1, -1, 1'b0);
        repeat (3) begin @(posedge clk); #2; end
        rdy_mode = 2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_hs_ready", 160'(bus.in_ready_o), 160'd1);
        chk("idle_after_hs_valid", 160'(bus.out_valid_o), 160'd0);
        @(posedge clk);
        #2;

        // Illegal GE80 and a mid-instruction fetch error.
        w = '{32'h0000_207F, 32'hAAAA_AAAA, 32'd0, 32'd0, 32'd0};
        send_instr(w, 32'h300, -1, 1'b1, -1, 1'b0);
        w = '{32'h0000_107F, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'd0, 32'd0};
        send_instr(w, 32'h400, 1, 1'b1, -1, 1'b0);

        // Flush after two words of a 5-word instruction, then a plain 1-word one.
        w = '{32'h0000_507F, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
        send_instr(w, 32'h500, -1, 1'b0, 2, 1'b0);
        flush = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_rdata_i = 32'h6666_6666;
        @(negedge clk);
        chk("flush_in_ready", 160'(bus.in_ready_o), 160'd0);
        @(posedge clk);
        #2;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        w = '{32'h0000_0013, 32'd0, 32'd0, 32'd0, 32'd0};
        send_instr(w, 32'h600, -1, 1'b1, -1, 1'b0);

        // Reset while a bundle is held.
        rdy_mode = 1;
        repeat (2) begin @(posedge clk); #2; end
        w = '{32'h0000_003F, 32'h1234_5678, 32'd0, 32'd0, 32'd0};
        send_instr(w, 32'h700, -1, 1'b0, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("hold_reset");
        #1;
        rst = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        chk("hold_reset_in_ready", 160'(bus.in_ready_o), 160'd1);
        @(posedge clk);
        #2;

        // Randomized traffic.
        rdy_mode = 0;
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < MW; k++) w[k] = $urandom;
            cls = $urandom_range(0, 4);
            case (cls)
                0: w[0] = {w[0][31:15], 3'd5, w[0][11:7], 7'h7F};
                1: w[0] = {w[0][31:15], 3'd1, w[0][11:7], 7'h7F};
                2: w[0] = {w[0][31:7], 7'h3F};
                3: begin
                    nnn = bad_nnn[$urandom_range(0, 5)];
                    w[0] = {w[0][31:15], nnn, w[0][11:7], 7'h7F};
                end
                default: if (w[0][6:0] == 7'h7F || w[0][6:0] == 7'h3F) w[0][0] = 1'b0;
            endcase
            probe = model(w, -1, 32'd0);
            err_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(probe.len) - 1)) : -1;
            send_instr(w, $urandom & 32'hFFFF_FFFC, err_at, 1'b1, -1, 1'b1);
        end

        rdy_mode = 2;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain", 160'(exp_q.size()), 160'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/isolde_vlen_fetch_assembler.md
Name: isolde_vlen_fetch_assembler

Overview:
- Sits between the Ibex fetch FIFO and the ISOLDE custom-instruction decoder.
- Collects one 32-bit fetch word per handshake and derives instruction length from the first word: 1, 2, 3 or 5 words.
- Presents the complete variable-length instruction, its length and its PC as one 160-bit bundle, with a valid/ready handshake into decode.

Parameters:
- MAX_WORDS, 5, width of the output bundle in 32-bit words; fixed at 5 for the current encodings.
- ADDR_W, 32, PC width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  kill on branch/exception; discards any partial or held instruction
- in_valid_i  in  1  fetch word valid
- in_ready_o  out  1  block accepts the word this cycle
- in_rdata_i  in  32  fetch word
- in_addr_i  in  ADDR_W  PC of the fetch word
- in_err_i  in  1  bus error on this fetch word
- out_valid_o  out  1  assembled instruction valid
- out_ready_i  in  1  decoder consumes the bundle
- out_instr_o  out  32*MAX_WORDS  word0 in [31:0], word k in [32k+31:32k]; unused words are zero
- out_len_o  out  3  number of words captured (1..5)
- out_addr_o  out  ADDR_W  PC of word0
- out_illegal_o  out  1  GE80 opcode with an unsupported nnn field
- out_err_o  out  1  fetch error on any captured word

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE.
  - out_valid_o=0, out_instr_o=0, out_len_o=0, out_addr_o=0, out_illegal_o=0, out_err_o=0.
  - Internal word counter and expected length are cleared.
  - Reset mid-instruction drops all partial data.
- Length decode on the first word (opcode=[6:0], nnn=[14:12]):
  - 7'b1111111 with nnn=5: length 5.
  - 7'b1111111 with nnn=1: length 3.
  - 7'b1111111 with any other nnn: length 1, and the illegal flag is set.
  - 7'b0111111: length 2.
  - Anything else: length 1.
- Words are accepted when in_valid_i && in_ready_o. in_ready_o = (state==IDLE || state==COLLECT) && !flush_i.
- State IDLE:
  - On accept, store word0 at slot 0 and capture in_addr_i and the length.
  - Go to HOLD if the length is 1 or in_err_i=1; otherwise go to COLLECT with cnt=1.
- State COLLECT:
  - On accept, store the word in slot cnt and increment cnt.
  - When cnt+1 equals the length, or in_err_i=1, go to HOLD.
  - in_addr_i of later words is ignored (no contiguity check).
- State HOLD:
  - out_valid_o=1. Outputs stay stable until the handshake completes.
  - When out_ready_i=1, go to IDLE and clear the slots and flags the next cycle.
  - No new word is accepted while in HOLD, so there is one idle fetch cycle per instruction.
- Latency: out_valid_o rises one cycle after the final word is accepted.
- Error handling:
  - in_err_i on any word terminates collection at once.
  - out_len_o = words captured including the erroring word; out_err_o=1.
  - Remaining slots are zero.
- Illegal: out_illegal_o=1 with out_len_o=1.
- Flush:
  - Highest priority after reset, in any state (including HOLD with out_ready_i=1 in the same cycle).
  - Next state is IDLE with out_valid_o=0, and all slots, counter and flags are cleared.
  - The word presented during the flush cycle is not accepted.
- Ordering of flags: out_illegal_o and out_err_o can both be 1 only if word0 is illegal and also carries an error.
- out_len_o width: 3 bits; values 1..5 only while valid.

Test Plan:
- 5-word instruction: word0=32'h0000_507F (GE80, nnn=5) at PC 0x100, then four words 0x11111111..0x44444444 with in_valid_i held high. Required: out_valid_o rises one cycle after the 5th accept; out_len_o=5; out_addr_o=0x100; out_instr_o[159:128]=0x44444444.
- 2-word instruction with backpressure: word0=32'h0E00_003F, word1=0xDEADBEEF; out_ready_i held low for 3 cycles. Required: bundle stable for those 3 cycles; in_ready_o=0 during them; IDLE after the handshake.
- Illegal GE80: word0=32'h0000_207F (nnn=2). Required: out_len_o=1, out_illegal_o=1, out_instr_o[159:32]=0.
- Mid-instruction error: 3-word instruction word0=32'h0000_107F, with word1 carrying in_err_i=1. Required: out_len_o=2, out_err_o=1, slot 2 = 0.
- Flush in COLLECT: flush_i pulsed after 2 of 5 words, then a 1-word instruction 0x00000013 is sent. Required: no output for the flushed instruction; the next bundle has out_len_o=1 and word0=0x13.
- Reset while in HOLD: rst_i=1 for one cycle. Required: out_valid_o=0 and all outputs zero on the next cycle; in_ready_o=1 once rst_i deasserts.
